// File: rtl/scan_risk_pkg.sv
// rtl/scan_risk_pkg.sv - shared types and constants for the scanRisk job scheduler
package scan_risk_pkg;

   localparam int NUM_POS = 8;
   localparam int RISK_W  = 16;

   typedef logic [NUM_POS-1:0][RISK_W-1:0] pos_vec_t;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} sched_state_t;

endpackage

// File: rtl/scan_req_arb.sv
// rtl/scan_req_arb.sv - one-hot requester arbiter for scan_risk_sched
// SCAN_RR_ARB_EN selects round-robin from a registered pointer; otherwise the lowest index wins.
module scan_req_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            take,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

`ifdef SCAN_RR_ARB_EN
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr_q, ptr_d;
   int            idx;
   logic          found;

   // Search wraps from the pointer; the pointer only moves when the grant is taken.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      ptr_d  = ptr_q;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (req[idx] && !found) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            if (take) begin
               ptr_d = PW'((idx + 1) % NREQ);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic found;
   logic unused_rr;

   assign unused_rr = ^{clk, rst_n, take};

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && !found) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            gnt_id = IDW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/scan_risk_sched.sv
// rtl/scan_risk_sched.sv - shares one scanRisk engine between NREQ requesters, one job at a time
// Arbitration mode is chosen by SCAN_RR_ARB_EN inside scan_req_arb.
module scan_risk_sched
   import scan_risk_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ENG_LAT = 2,
   parameter int IDW     = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ-1:0][RISK_W-1:0] req_psr,
   input  pos_vec_t [NREQ-1:0]         req_pos,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [IDW-1:0]              rsp_id,
   output logic [RISK_W-1:0]           rsp_risk,
   output logic                        eng_reset,
   output logic [RISK_W-1:0]           eng_psr,
   output pos_vec_t                    eng_pos,
   input  logic [RISK_W-1:0]           eng_risk,
   output logic                        busy,
   output logic [15:0]                 job_cnt
);

   localparam int LCW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

   sched_state_t      state_q, state_d;
   logic [RISK_W-1:0] psr_q, psr_d;
   pos_vec_t          pos_q, pos_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [RISK_W-1:0] risk_q, risk_d;
   logic [LCW-1:0]    lat_q, lat_d;
   logic [15:0]       cnt_q, cnt_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gnt_id;
   logic              accept_ok;

   // Qualifying with reset keeps req_ready low while the block is held in reset.
   assign accept_ok = (state_q == IDLE) && reset;

   scan_req_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk    (clk),
      .rst_n  (reset),
      .req    (req_valid),
      .take   (accept_ok),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      state_d   = state_q;
      psr_d     = psr_q;
      pos_d     = pos_q;
      id_d      = id_q;
      risk_d    = risk_q;
      lat_d     = lat_q;
      cnt_d     = cnt_q;
      eng_reset = 1'b0;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (gnt[i]) begin
                     psr_d = req_psr[i];
                     pos_d = req_pos[i];
                  end
               end
               id_d    = gnt_id;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            lat_d   = LCW'(ENG_LAT - 1);
            state_d = RUN;
         end
         RUN: begin
            eng_reset = 1'b1;
            if (lat_q == '0) begin
               risk_d  = eng_risk;
               state_d = RESP;
            end else begin
               lat_d = lat_q - LCW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         psr_q   <= '0;
         pos_q   <= '0;
         id_q    <= '0;
         risk_q  <= '0;
         lat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         psr_q   <= psr_d;
         pos_q   <= pos_d;
         id_q    <= id_d;
         risk_q  <= risk_d;
         lat_q   <= lat_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready = accept_ok ? gnt : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_risk  = risk_q;
   assign eng_psr   = psr_q;
   assign eng_pos   = pos_q;
   assign busy      = (state_q != IDLE);
   assign job_cnt   = cnt_q;

endmodule

// File: tb/tb_scan_risk_sched.sv
// tb/tb_scan_risk_sched.sv - randomized self-checking bench for scan_risk_sched against a job-level model
module tb_scan_risk_sched;

   localparam int NREQ    = 4;
   localparam int ENG_LAT = 2;
   localparam int IDW     = 3;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [NREQ-1:0]          req_valid = '0;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ-1:0][15:0]    req_psr = '0;
   logic [NREQ-1:0][7:0][15:0] req_pos = '0;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b0;
   logic [IDW-1:0]           rsp_id;
   logic [15:0]              rsp_risk;
   logic                     eng_reset;
   logic [15:0]              eng_psr;
   logic [7:0][15:0]         eng_pos;
   logic [15:0]              eng_risk;
   logic                     busy;
   logic [15:0]              job_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   scan_risk_sched #(.NREQ(NREQ), .ENG_LAT(ENG_LAT), .IDW(IDW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_psr(req_psr), .req_pos(req_pos),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_risk(rsp_risk),
      .eng_reset(eng_reset), .eng_psr(eng_psr), .eng_pos(eng_pos), .eng_risk(eng_risk),
      .busy(busy), .job_cnt(job_cnt)
   );

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scanning risk = price scan range times absolute net position, 16-bit result.
   function automatic logic [15:0] risk_of(input logic [15:0] psr, input logic [7:0][15:0] pos);
      int net = 0;
      for (int i = 0; i < 8; i++) net += int'($signed(pos[i]));
      if (net < 0) net = -net;
      return 16'(int'(psr) * net);
   endfunction

   // Engine stand-in: output is only meaningful once it has run ENG_LAT cycles out of clear.
   int eng_age = 0;
   always @(posedge clk) eng_age <= eng_reset ? eng_age + 1 : 0;
   assign eng_risk = (eng_age >= ENG_LAT - 1) ? risk_of(eng_psr, eng_pos) : 16'hBAD0;

   // Job-level reference model, evaluated on the falling edge.
   bit               inflight = 0;
   int               acc_cyc = 0;
   int               cyc = 0;
   int               exp_id = 0;
   logic [15:0]      exp_psr = '0;
   logic [15:0]      exp_risk = '0;
   logic [7:0][15:0] exp_pos = '0;
   logic [15:0]      exp_cnt = '0;
   int               grant_log[$];
`ifdef SCAN_RR_ARB_EN
   int               rr_ptr = 0;
`endif

   function automatic int pick(input logic [NREQ-1:0] v);
`ifdef SCAN_RR_ARB_EN
      for (int k = 0; k < NREQ; k++) if (v[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
      return -1;
   endfunction

   always @(negedge clk) begin : mon
      int w;
      int d;
      cyc++;
      if (!reset) begin
         chk_eq("rst_req_ready", req_ready, 0);
         chk_eq("rst_rsp_valid", rsp_valid, 0);
         chk_eq("rst_busy", busy, 0);
         chk_eq("rst_eng_reset", eng_reset, 0);
         chk_eq("rst_eng_psr", eng_psr, 0);
         chk_eq("rst_eng_pos", eng_pos, 0);
         chk_eq("rst_job_cnt", job_cnt, 0);
         chk_eq("rst_rsp_risk", rsp_risk, 0);
         chk_eq("rst_rsp_id", rsp_id, 0);
         inflight = 0;
         exp_cnt  = '0;
`ifdef SCAN_RR_ARB_EN
         rr_ptr = 0;
`endif
      end else begin
         chk_eq("job_cnt", job_cnt, exp_cnt);
         chk_eq("busy", busy, inflight);
         if (!inflight) begin
            w = pick(req_valid);
            chk_eq("req_ready", req_ready, (w >= 0) ? (NREQ'(1) << w) : NREQ'(0));
            chk_eq("idle_rsp_valid", rsp_valid, 0);
            chk_eq("idle_eng_reset", eng_reset, 0);
            if (w >= 0) begin
               inflight = 1;
               acc_cyc  = cyc;
               exp_id   = w;
               exp_psr  = req_psr[w];
               exp_pos  = req_pos[w];
               exp_risk = risk_of(req_psr[w], req_pos[w]);
               grant_log.push_back(w);
`ifdef SCAN_RR_ARB_EN
               rr_ptr = (w + 1) % NREQ;
`endif
            end
         end else begin
            d = cyc - acc_cyc;
            chk_eq("busy_req_ready", req_ready, 0);
            chk_eq("eng_psr", eng_psr, exp_psr);
            chk_eq("eng_pos", eng_pos, exp_pos);
            chk_eq("eng_reset", eng_reset, (d >= 2 && d <= ENG_LAT + 1));
            chk_eq("rsp_valid", rsp_valid, (d >= ENG_LAT + 2));
            if (d >= ENG_LAT + 2) begin
               chk_eq("rsp_id", rsp_id, exp_id);
               chk_eq("rsp_risk", rsp_risk, exp_risk);
               if (rsp_ready) begin
                  inflight = 0;
                  exp_cnt  = exp_cnt + 16'd1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string tag);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk_eq({tag, "_timeout"}, 0, 1);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int base;
      int exp_ord[4];
      logic [15:0] bp_risk;

      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Single job: psr 100, net position 8.
      req_psr[0] = 16'd100;
      for (int i = 0; i < 8; i++) req_pos[0][i] = 16'd1;
      req_valid = 4'b0001;
      tick();
      lat = 1;
      req_valid = '0;
      while (!rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk_eq("t1_latency", lat, ENG_LAT + 2);
      chk_eq("t1_risk", rsp_risk, 16'd800);
      chk_eq("t1_id", rsp_id, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_eq("t1_job_cnt", job_cnt, 1);

      // Net-zero portfolio.
      req_psr[1] = 16'd200;
      req_pos[1] = '0;
      req_pos[1][0] = 16'd5;
      req_pos[1][1] = 16'hFFFB;
      req_pos[1][2] = 16'd3;
      req_pos[1][3] = 16'hFFFD;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      wait_rsp("t2");
      chk_eq("t2_risk", rsp_risk, 0);
      chk_eq("t2_id", rsp_id, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_eq("t2_job_cnt", job_cnt, 2);

      // Arbitration order with requesters 0 and 2 held.
      pulse_reset();
`ifdef SCAN_RR_ARB_EN
      exp_ord = '{0, 2, 0, 2};
`else
      exp_ord = '{0, 0, 0, 0};
`endif
      base = grant_log.size();
      req_valid = 4'b0101;
      rsp_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (grant_log.size() >= base + 4) break;
         tick();
      end
      req_valid = '0;
      for (int i = 0; i < 4; i++)
         chk_eq("arb_order", (grant_log.size() > base + i) ? grant_log[base + i] : -1, exp_ord[i]);
      repeat (10) tick();

      // Backpressure with requester 1 pending.
      rsp_ready = 1'b0;
      req_psr[0] = 16'd37;
      for (int i = 0; i < 8; i++) req_pos[0][i] = 16'(i) - 16'd2;
      bp_risk = risk_of(req_psr[0], req_pos[0]);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0010;
      wait_rsp("bp");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_eq("bp_valid", rsp_valid, 1);
         chk_eq("bp_risk", rsp_risk, bp_risk);
         chk_eq("bp_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk_eq("bp_grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (8) tick();

      // Reset in the middle of RUN.
      req_psr[3] = 16'd9;
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      #1;
      reset = 1'b0;
      #1;
      chk_eq("mid_busy", busy, 0);
      chk_eq("mid_eng_reset", eng_reset, 0);
      chk_eq("mid_eng_psr", eng_psr, 0);
      chk_eq("mid_rsp_valid", rsp_valid, 0);
      chk_eq("mid_job_cnt", job_cnt, 0);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_eq("mid_no_rsp", rsp_valid, 0);
      end
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      wait_rsp("mid");
      tick();
      chk_eq("mid_next_cnt", job_cnt, 1);
      repeat (3) tick();

      // Counter wrap.
      force dut.cnt_q = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      tick();
      release dut.cnt_q;
      tick();
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp("wrap");
      tick();
      chk_eq("wrap_cnt", job_cnt, 0);

      // Randomized traffic, checked continuously by the model.
      for (int c = 0; c < 1500; c++) begin
         req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         if ($urandom_range(0, 2) == 0) req_valid = '0;
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < NREQ; r++) begin
            req_psr[r] = 16'($urandom_range(0, 1000));
            for (int p = 0; p < 8; p++) req_pos[r][p] = 16'(int'($urandom_range(0, 200)) - 100);
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
